hazard_stall_unit: RTL and testbench

- Pipeline control block for the 5-stage RV32I core. It decides when the pipeline advances, stalls, bubbles or flushes.
- The forwarding path handles the dependencies it can resolve by bypass. This block handles the rest:
  - load-use hazards, which are resolved by stalling;
  - instruction and data memory latency, which freezes the pipeline;
  - taken-branch squashes.
- It also tracks single-cycle memory responses that arrive while the pipeline is frozen, so each response is consumed exactly once.

---
 rtl/hazard_stall_unit_if.sv | 39 +++
 rtl/hazard_stall_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Memory handshake bundle between the pipeline control block and the
// instruction/data memory ports plus their datapath hold registers.
interface hazard_stall_unit_if;
    logic imem_read;
    logic imem_resp;
    logic dmem_read;
    logic dmem_write;
    logic dmem_resp;
    logic imem_capture;
    logic dmem_capture;
    logic imem_use_hold;
    logic dmem_use_hold;

    // Controller side: issues requests, sees single-cycle responses.
    modport master (
        output imem_read,
        output dmem_read,
        output dmem_write,
        output imem_capture,
        output dmem_capture,
        output imem_use_hold,
        output dmem_use_hold,
        input  imem_resp,
        input  dmem_resp
    );

    // Memory/datapath side.
    modport slave (
        input  imem_read,
        input  dmem_read,
        input  dmem_write,
        input  imem_capture,
        input  dmem_capture,
        input  imem_use_hold,
        input  dmem_use_hold,
        output imem_resp,
        output dmem_resp
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline control for the 5-stage RV32I core: load-use stalls, memory
// latency freezes, taken-branch squashes and response hold tracking.
module hazard_stall_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_br_taken,
    input  logic             exmem_dmem_read,
    input  logic             exmem_dmem_write,
    hazard_stall_unit_if.master mem,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;
    logic   imem_done;
    logic   dmem_done;

    logic dmem_req;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic rs1_hit;
    logic rs2_hit;
    logic lu;

    // Readiness of each memory side and the load-use match.
    always_comb begin
        dmem_req = exmem_dmem_read | exmem_dmem_write;
        i_ok     = mem.imem_resp | imem_done;
        d_ok     = ~dmem_req | mem.dmem_resp | dmem_done;
        advance  = i_ok & d_ok;
        rs1_hit  = ifid_use_rs1 & (ifid_rs1 == idex_rd);
        rs2_hit  = ifid_use_rs2 & (ifid_rs2 == idex_rd);
        lu       = idex_mem_read & (idex_rd != 5'd0)
                 & (rs1_hit | rs2_hit);
    end

    // Requests, captures and hold selects; everything is forced low in reset.
    always_comb begin
        mem.imem_read     = 1'b0;
        mem.dmem_read     = 1'b0;
        mem.dmem_write    = 1'b0;
        mem.imem_capture  = 1'b0;
        mem.dmem_capture  = 1'b0;
        mem.imem_use_hold = 1'b0;
        mem.dmem_use_hold = 1'b0;
        if (!rst) begin
            // A completed request stays quiet until the pipeline moves on.
            mem.imem_read     = ~imem_done;
            mem.dmem_read     = exmem_dmem_read & ~dmem_done;
            mem.dmem_write    = exmem_dmem_write & ~dmem_done;
            // Hold a response only when the other side is still pending.
            mem.imem_capture  = mem.imem_resp & ~d_ok;
            mem.dmem_capture  = mem.dmem_resp & ~i_ok;
            mem.imem_use_hold = imem_done;
            mem.dmem_use_hold = dmem_done;
        end
    end

    // Stage enables: freeze beats squash beats load-use bubble beats run.
    always_comb begin
        load_pc     = 1'b0;
        load_ifid   = 1'b0;
        load_idex   = 1'b0;
        load_exmem  = 1'b0;
        load_memwb  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                ~advance: begin
                    load_pc = 1'b0;
                end
                advance & exmem_br_taken: begin
                    // The ID instruction is squashed, so lu is moot.
                    load_pc    = 1'b1;
                    load_ifid  = 1'b1;
                    load_idex  = 1'b1;
                    load_exmem = 1'b1;
                    load_memwb = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                advance & ~exmem_br_taken & lu: begin
                    // Hold PC and IF/ID one cycle, drop a NOP into EX.
                    load_idex   = 1'b1;
                    bubble_idex = 1'b1;
                    load_exmem  = 1'b1;
                    load_memwb  = 1'b1;
                end
                advance & ~exmem_br_taken & ~lu: begin
                    load_pc    = 1'b1;
                    load_ifid  = 1'b1;
                    load_idex  = 1'b1;
                    load_exmem = 1'b1;
                    load_memwb = 1'b1;
                end
                default: begin
                    load_pc = 1'b0;
                end
            endcase
        end
    end

    // Response flags, debug state and the stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            imem_done   <= 1'b0;
            dmem_done   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (advance) begin
                imem_done <= 1'b0;
                dmem_done <= 1'b0;
            end else begin
                if (mem.imem_resp) imem_done <= 1'b1;
                if (mem.dmem_resp) dmem_done <= 1'b1;
            end
            unique case (state)
                RUN:     if (!advance) state <= WAIT;
                WAIT:    if (advance)  state <= RUN;
                default: state <= RUN;
            endcase
            if (!load_pc) stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a reference model pushes the
// expected outputs each cycle and they are popped against the DUT.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ifid_rs1 = '0;
    logic [4:0]  ifid_rs2 = '0;
    logic        ifid_use_rs1 = 1'b0;
    logic        ifid_use_rs2 = 1'b0;
    logic        idex_mem_read = 1'b0;
    logic [4:0]  idex_rd = '0;
    logic        exmem_br_taken = 1'b0;
    logic        exmem_dmem_read = 1'b0;
    logic        exmem_dmem_write = 1'b0;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        bubble_idex, flush_ifid, flush_idex;
    logic [31:0] stall_count;

    hazard_stall_unit_if mif ();

    hazard_stall_unit #(.CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifid_rs1         (ifid_rs1),
        .ifid_rs2         (ifid_rs2),
        .ifid_use_rs1     (ifid_use_rs1),
        .ifid_use_rs2     (ifid_use_rs2),
        .idex_mem_read    (idex_mem_read),
        .idex_rd          (idex_rd),
        .exmem_br_taken   (exmem_br_taken),
        .exmem_dmem_read  (exmem_dmem_read),
        .exmem_dmem_write (exmem_dmem_write),
        .mem              (mif.master),
        .load_pc          (load_pc),
        .load_ifid        (load_ifid),
        .load_idex        (load_idex),
        .load_exmem       (load_exmem),
        .load_memwb       (load_memwb),
        .bubble_idex      (bubble_idex),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [14:0] v;
        logic [31:0] c;
        logic        w;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic        m_idone = 1'b0;
    logic        m_ddone = 1'b0;
    logic        m_wait = 1'b0;
    logic [31:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {mif.imem_read, mif.dmem_read, mif.dmem_write,
                mif.imem_capture, mif.dmem_capture,
                mif.imem_use_hold, mif.dmem_use_hold,
                load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                bubble_idex, flush_ifid, flush_idex};
    endfunction

    // Called at a falling edge with inputs already applied.
    task automatic cyc(input string tag);
        exp_t e;
        logic req, iok, dok, adv, luh;
        logic lp, lf, li, le, lm, bb, fi, fx;
        logic ir, dr, dw, ic, dc;
        if (rst) begin
            m_idone = 1'b0;
            m_ddone = 1'b0;
            m_wait  = 1'b0;
            m_cnt   = '0;
        end
        req = exmem_dmem_read | exmem_dmem_write;
        iok = mif.imem_resp | m_idone;
        dok = !req || mif.dmem_resp || m_ddone;
        adv = iok & dok;
        luh = idex_mem_read && idex_rd != 0
              && ((ifid_use_rs1 && ifid_rs1 == idex_rd)
              ||  (ifid_use_rs2 && ifid_rs2 == idex_rd));
        ir = !m_idone;
        dr = exmem_dmem_read && !m_ddone;
        dw = exmem_dmem_write && !m_ddone;
        ic = mif.imem_resp && !dok;
        dc = mif.dmem_resp && !iok;
        {lp, lf, li, le, lm, bb, fi, fx} = '0;
        if (!adv) begin
            lp = 1'b0;
        end else if (exmem_br_taken) begin
            {lp, lf, li, le, lm} = 5'b11111;
            {fi, fx} = 2'b11;
        end else if (luh) begin
            {li, le, lm, bb} = 4'b1111;
        end else begin
            {lp, lf, li, le, lm} = 5'b11111;
        end
        e.tag = tag;
        e.c   = m_cnt;
        e.w   = m_wait;
        if (rst)
            e.v = '0;
        else
            e.v = {ir, dr, dw, ic, dc, m_idone, m_ddone,
                   lp, lf, li, le, lm, bb, fi, fx};
        sbq.push_back(e);
        #2;
        e = sbq.pop_front();
        chk({e.tag, ":outs"}, 64'(outs()), 64'(e.v));
        chk({e.tag, ":cnt"}, 64'(stall_count), 64'(e.c));
        chk({e.tag, ":state"}, 64'(dut.state), 64'(e.w));
        @(posedge clk);
        if (!rst) begin
            if (adv) begin
                m_idone = 1'b0;
                m_ddone = 1'b0;
            end else begin
                if (mif.imem_resp) m_idone = 1'b1;
                if (mif.dmem_resp) m_ddone = 1'b1;
            end
            m_wait = !adv;
            if (!lp) m_cnt = m_cnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        ifid_rs1 = '0;
        ifid_rs2 = '0;
        ifid_use_rs1 = 1'b0;
        ifid_use_rs2 = 1'b0;
        idex_mem_read = 1'b0;
        idex_rd = '0;
        exmem_br_taken = 1'b0;
        exmem_dmem_read = 1'b0;
        exmem_dmem_write = 1'b0;
        mif.imem_resp = 1'b0;
        mif.dmem_resp = 1'b0;
    endtask

    logic [31:0] c0;

    initial begin
        idle();
        @(negedge clk);
        #1;
        chk("rst_outs", 64'(outs()), 64'd0);
        chk("rst_cnt", 64'(stall_count), 64'd0);
        cyc("rst");
        rst = 1'b0;

        // 1: plain run, imem answers every cycle
        for (int i = 0; i < 4; i++) begin
            mif.imem_resp = 1'b1;
            cyc("t1");
        end
        chk("t1_cnt", 64'(stall_count), 64'd0);

        // 2: load-use on rs2
        c0 = m_cnt;
        idex_mem_read = 1'b1;
        idex_rd = 5'd5;
        ifid_rs2 = 5'd5;
        ifid_use_rs2 = 1'b1;
        #1;
        chk("t2_lpc", 64'(load_pc), 64'd0);
        chk("t2_bub", 64'(bubble_idex), 64'd1);
        cyc("t2_hz");
        idle();
        mif.imem_resp = 1'b1;
        cyc("t2_go");
        chk("t2_cnt", 64'(stall_count), 64'(c0 + 1));

        // 3: same pattern on x0 is harmless
        idex_mem_read = 1'b1;
        ifid_rs2 = 5'd0;
        ifid_use_rs2 = 1'b1;
        #1;
        chk("t3_lpc", 64'(load_pc), 64'd1);
        cyc("t3");

        // 4: imem answers at 1, dmem at 4
        idle();
        c0 = m_cnt;
        exmem_dmem_read = 1'b1;
        cyc("t4_c0");
        mif.imem_resp = 1'b1;
        #1;
        chk("t4_icap", 64'(mif.imem_capture), 64'd1);
        cyc("t4_c1");
        mif.imem_resp = 1'b0;
        #1;
        chk("t4_ird2", 64'(mif.imem_read), 64'd0);
        cyc("t4_c2");
        cyc("t4_c3");
        mif.dmem_resp = 1'b1;
        #1;
        chk("t4_hold", 64'(mif.imem_use_hold), 64'd1);
        chk("t4_lpc", 64'(load_pc), 64'd1);
        cyc("t4_c4");
        chk("t4_cnt", 64'(stall_count), 64'(c0 + 4));
        idle();
        mif.imem_resp = 1'b1;
        #1;
        chk("t4_clr", 64'(mif.imem_use_hold), 64'd0);
        cyc("t4_c5");

        // 5: branch squash wins over load-use
        exmem_br_taken = 1'b1;
        idex_mem_read = 1'b1;
        idex_rd = 5'd7;
        ifid_rs1 = 5'd7;
        ifid_use_rs1 = 1'b1;
        #1;
        chk("t5_fl", 64'({flush_ifid, flush_idex, bubble_idex, load_pc}),
            64'b1101);
        cyc("t5");

        // 6: reset in the middle of a stall
        idle();
        rst = 1'b1;
        cyc("t6_rst");
        rst = 1'b0;
        exmem_dmem_read = 1'b1;
        cyc("t6_s0");
        mif.dmem_resp = 1'b1;
        cyc("t6_s1");
        mif.dmem_resp = 1'b0;
        cyc("t6_s2");
        chk("t6_cnt3", 64'(stall_count), 64'd3);
        chk("t6_dh", 64'(mif.dmem_use_hold), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_zero", 64'(outs()), 64'd0);
        chk("t6_czero", 64'(stall_count), 64'd0);
        cyc("t6_in");
        rst = 1'b0;
        #1;
        chk("t6_drd", 64'(mif.dmem_read), 64'd1);
        chk("t6_cnt0", 64'(stall_count), 64'd0);
        mif.imem_resp = 1'b1;
        mif.dmem_resp = 1'b1;
        #1;
        chk("t6_nocap",
            64'({mif.imem_capture, mif.dmem_capture, load_pc}), 64'b001);
        cyc("t6_both");

        // random legal traffic
        for (int i = 0; i < 300; i++) begin
            ifid_rs1 = 5'($urandom_range(0, 3));
            ifid_rs2 = 5'($urandom_range(0, 3));
            ifid_use_rs1 = 1'($urandom);
            ifid_use_rs2 = 1'($urandom);
            idex_mem_read = 1'($urandom);
            idex_rd = 5'($urandom_range(0, 3));
            exmem_br_taken = ($urandom_range(0, 7) == 0);
            exmem_dmem_read = 1'($urandom);
            exmem_dmem_write = !exmem_dmem_read && ($urandom_range(0, 3) == 0);
            mif.imem_resp = !m_idone && ($urandom_range(0, 2) != 0);
            mif.dmem_resp = !m_ddone
                            && (exmem_dmem_read || exmem_dmem_write)
                            && ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc("rnd");
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
